// File: rtl/trace_sram_fifo_ctrl.sv
// Streaming FIFO controller around a 64x256 dual-port trace SRAM: lossy capture side,
// valid/ready readout side with a 2-entry output buffer hiding the SRAM read latency.
module trace_sram_fifo_ctrl #(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 8,
   parameter int DEPTH          = 1 << ADDR_WIDTH,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      in_valid,
   input  logic [DATA_WIDTH-1:0]     in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_data,
   output logic [ADDR_WIDTH:0]       level,
   output logic                      empty,
   output logic                      full,
   output logic                      overflow,
   output logic [DROP_CNT_WIDTH-1:0] drop_count,
   output logic                      sram_wr_csb,
   output logic                      sram_wr_web,
   output logic [DATA_WIDTH/8-1:0]   sram_wr_wmask,
   output logic [ADDR_WIDTH-1:0]     sram_wr_addr,
   output logic [DATA_WIDTH-1:0]     sram_wr_data,
   output logic                      sram_rd_csb,
   output logic [ADDR_WIDTH-1:0]     sram_rd_addr,
   input  logic [DATA_WIDTH-1:0]     sram_rd_data
);

   localparam logic [ADDR_WIDTH:0] FULL_OCC = (ADDR_WIDTH + 1)'(DEPTH);

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic [ADDR_WIDTH:0]   occ;
   logic                  inflight;
   logic [1:0]            outbuf_cnt;
   logic [DATA_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0] skid;
   logic                  flush;
   logic                  do_write;
   logic                  do_drop;
   logic                  do_read;
   logic                  pop;

   assign flush     = rst | clear;
   assign occ       = wr_ptr - rd_ptr;
   assign full      = (occ == FULL_OCC);
   assign out_valid = (outbuf_cnt != 2'd0);
   assign out_data  = head;
   assign pop       = out_valid & out_ready;

   assign do_write  = !flush && in_valid && !full;
   assign do_drop   = !flush && in_valid && full;

   // A pop this cycle frees a buffer slot in time for the returning word, which keeps 1 word/cycle.
   assign do_read   = !flush && (occ != '0) &&
                      ((3'(outbuf_cnt) + 3'(inflight)) < (3'd2 + 3'(pop)));

   assign level     = occ + (ADDR_WIDTH + 1)'(inflight) + (ADDR_WIDTH + 1)'(outbuf_cnt);
   assign empty     = (level == '0);

   assign sram_wr_csb   = !do_write;
   assign sram_wr_web   = !do_write;
   assign sram_wr_wmask = '1;
   assign sram_wr_addr  = wr_ptr[ADDR_WIDTH-1:0];
   assign sram_wr_data  = in_data;
   assign sram_rd_csb   = !do_read;
   assign sram_rd_addr  = rd_ptr[ADDR_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         inflight   <= 1'b0;
         outbuf_cnt <= 2'd0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (do_write)
            wr_ptr <= wr_ptr + (ADDR_WIDTH + 1)'(1);
         if (do_read)
            rd_ptr <= rd_ptr + (ADDR_WIDTH + 1)'(1);
         inflight   <= do_read;
         outbuf_cnt <= outbuf_cnt + 2'(inflight) - 2'(pop);
         if (do_drop) begin
            overflow <= 1'b1;
            if (drop_count != '1)
               drop_count <= drop_count + DROP_CNT_WIDTH'(1);
         end
      end
   end

   // Returning data is only taken when a read was issued last cycle and no flush intervened,
   // so a read issued just before clear never reaches the buffer.
   always_ff @(posedge clk) begin
      if (inflight && !flush) begin
         if (outbuf_cnt == 2'd0 || (outbuf_cnt == 2'd1 && pop)) begin
            head <= sram_rd_data;
         end else if (outbuf_cnt == 2'd2 && pop) begin
            head <= skid;
            skid <= sram_rd_data;
         end else begin
            skid <= sram_rd_data;
         end
      end else if (!flush && pop && outbuf_cnt == 2'd2) begin
         head <= skid;
      end
   end

endmodule

// File: tb/tb_trace_sram_fifo_ctrl.sv
// Self-checking bench for trace_sram_fifo_ctrl: a cycle table for the startup sequence plus
// directed fill/drain, streaming, random, clear and drop-saturation sequences against a behavioural SRAM.
module tb_trace_sram_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [8:0]  level;
   logic        empty;
   logic        full;
   logic        overflow;
   logic [15:0] drop_count;
   logic        sram_wr_csb;
   logic        sram_wr_web;
   logic [7:0]  sram_wr_wmask;
   logic [7:0]  sram_wr_addr;
   logic [63:0] sram_wr_data;
   logic        sram_rd_csb;
   logic [7:0]  sram_rd_addr;
   logic [63:0] sram_rd_data;

   int compared   = 0;
   int mismatched = 0;
   int model_level = 0;
   int pop_count  = 0;
   int mask_err   = 0;
   int addr0_writes = 0;
   logic [63:0] sbq[$];
   logic [63:0] mem [256];

   always #5 clk = ~clk;

   trace_sram_fifo_ctrl dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .empty(empty), .full(full),
      .overflow(overflow), .drop_count(drop_count),
      .sram_wr_csb(sram_wr_csb), .sram_wr_web(sram_wr_web), .sram_wr_wmask(sram_wr_wmask),
      .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
      .sram_rd_csb(sram_rd_csb), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data)
   );

   // Behavioural SRAM: synchronous write, read data registered one cycle after the request.
   always @(posedge clk) begin
      if (!sram_wr_csb && !sram_wr_web) begin
         mem[sram_wr_addr] <= sram_wr_data;
         if (sram_wr_wmask != 8'hFF) mask_err++;
         if (sram_wr_addr == 8'd0) addr0_writes++;
      end
      if (!sram_rd_csb)
         sram_rd_data <= mem[sram_rd_addr];
   end

   typedef struct {
      logic        iv;
      logic [63:0] id;
      logic        rdy;
      logic        ov;
      logic [63:0] od;
      logic [8:0]  lvl;
      logic        wcsb;
      logic        rcsb;
      logic        emp;
   } vec_t;

   vec_t vecs[7];

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      in_valid  = v.iv;
      in_data   = v.id;
      out_ready = v.rdy;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      checkVal($sformatf("vec%0d_out_valid", idx), out_valid, v.ov);
      if (v.ov) checkVal($sformatf("vec%0d_out_data", idx), out_data, v.od);
      checkVal($sformatf("vec%0d_level", idx), level, v.lvl);
      checkVal($sformatf("vec%0d_wr_csb", idx), sram_wr_csb, v.wcsb);
      checkVal($sformatf("vec%0d_rd_csb", idx), sram_rd_csb, v.rcsb);
      checkVal($sformatf("vec%0d_empty", idx), empty, v.emp);
   endtask

   // One clock cycle starting and ending at posedge+1, with scoreboard bookkeeping.
   task automatic stepCycle(input logic iv, input logic [63:0] id, input logic rdy,
                            input bit push, input bit chk_level, output logic sampled_valid);
      if (chk_level) checkVal("level_model", level, 64'(model_level));
      in_valid  = iv;
      in_data   = id;
      out_ready = rdy;
      #1;
      sampled_valid = out_valid;
      if (out_valid && out_ready) begin
         pop_count++;
         model_level--;
         if (sbq.size() == 0) checkVal("unexpected_pop", 1, 0);
         else checkVal("fifo_order", out_data, sbq.pop_front());
      end
      if (push) begin
         sbq.push_back(id);
         model_level++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic doClear();
      clear     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      clear = 1'b0;
      sbq.delete();
      model_level = 0;
   endtask

   task automatic drainAll(input int budget);
      logic v;
      int n = 0;
      while (sbq.size() > 0 && n < budget) begin
         stepCycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, v);
         n++;
      end
      checkVal("drain_complete", 64'(sbq.size()), 0);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic v;
      int   low_cnt;
      int   wait_n;
      bit   found;

      vecs[0] = '{1'b1, 64'hA0, 1'b1, 1'b0, 64'h0,  9'd0, 1'b0, 1'b1, 1'b1};
      vecs[1] = '{1'b1, 64'hA1, 1'b1, 1'b0, 64'h0,  9'd1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 64'hA2, 1'b1, 1'b0, 64'h0,  9'd2, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'hA0, 9'd3, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'hA1, 9'd2, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 64'h0,  1'b1, 1'b1, 64'hA2, 9'd1, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 64'h0,  1'b1, 1'b0, 64'h0,  9'd0, 1'b1, 1'b1, 1'b1};

      rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkVal("wr_csb_in_reset", sram_wr_csb, 1);
      checkVal("rd_csb_in_reset", sram_rd_csb, 1);
      rst = 1'b0; in_valid = 1'b0;
      checkVal("rst_level", level, 0);
      checkVal("rst_empty", empty, 1);
      checkVal("rst_full", full, 0);
      checkVal("rst_overflow", overflow, 0);
      checkVal("rst_drop_count", drop_count, 0);
      checkVal("rst_out_valid", out_valid, 0);

      $display("[TB] startup latency/throughput table");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput(vecs[i], i);
         @(posedge clk);
         #1;
      end

      $display("[TB] fill to capacity with drops, then drain");
      doClear();
      for (int k = 0; k < 260; k++) begin
         if (k == 258) begin
            in_valid = 1'b1; out_ready = 1'b0;
            #1;
            checkVal("wr_csb_when_full", sram_wr_csb, 1);
         end
         stepCycle(1'b1, {32'hDEAD_0000, 32'(k)}, 1'b0, k < 258, 1'b0, v);
      end
      in_valid = 1'b0;
      checkVal("fill_full", full, 1);
      checkVal("fill_level", level, 258);
      checkVal("fill_overflow", overflow, 1);
      checkVal("fill_drop_count", drop_count, 2);
      pop_count = 0;
      drainAll(400);
      checkVal("drain_pops", 64'(pop_count), 258);
      checkVal("drain_level", level, 0);
      checkVal("drain_empty", empty, 1);
      checkVal("drain_full", full, 0);

      $display("[TB] continuous streaming across address wrap");
      doClear();
      addr0_writes = 0;
      pop_count = 0;
      low_cnt = 0;
      for (int c = 0; c < 610; c++) begin
         stepCycle(c < 600, {32'h3000_0000, 32'(c)}, 1'b1, c < 600, 1'b1, v);
         if (c >= 3 && c <= 602 && !v) low_cnt++;
      end
      checkVal("stream_bubbles", 64'(low_cnt), 0);
      checkVal("stream_pops", 64'(pop_count), 600);
      checkVal("stream_addr0_writes", 64'(addr0_writes), 3);
      checkVal("stream_drops", drop_count, 0);
      checkVal("stream_empty", empty, 1);

      $display("[TB] random traffic");
      doClear();
      for (int c = 0; c < 2000; c++) begin
         logic iv;
         iv = ($urandom_range(0, 99) < 50);
         stepCycle(iv, {$urandom, $urandom}, ($urandom_range(0, 99) >= 30), iv, 1'b1, v);
      end
      drainAll(400);
      checkVal("rand_overflow", overflow, 0);
      checkVal("rand_drops", drop_count, 0);
      checkVal("rand_level", level, 0);

      $display("[TB] clear with a read in flight");
      doClear();
      in_valid = 1'b1; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_data = {32'h5000_0000, 32'(k)};
         @(posedge clk);
         #1;
      end
      clear = 1'b1; in_data = 64'hBAD0_BAD0;
      #1;
      checkVal("pre_clear_out_valid", out_valid, 1);
      checkVal("rd_csb_in_clear", sram_rd_csb, 1);
      checkVal("wr_csb_in_clear", sram_wr_csb, 1);
      @(posedge clk);
      #1;
      clear = 1'b0; in_valid = 1'b0;
      checkVal("clear_out_valid", out_valid, 0);
      checkVal("clear_level", level, 0);
      checkVal("clear_overflow", overflow, 0);
      checkVal("clear_empty", empty, 1);
      in_valid = 1'b1; in_data = 64'h55; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      found = 1'b0;
      wait_n = 1;
      while (!found && wait_n < 10) begin
         if (out_valid) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
            wait_n++;
         end
      end
      checkVal("post_clear_word_seen", found, 1);
      checkVal("post_clear_latency", 64'(wait_n), 3);
      checkVal("post_clear_data", out_data, 64'h55);
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
         checkVal("post_clear_no_stale", out_valid, 0);
         @(posedge clk);
         #1;
      end
      checkVal("post_clear_level", level, 0);

      $display("[TB] drop counter saturation");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      for (int k = 0; k < 258 + 65540; k++) begin
         in_data = {32'h6000_0000, 32'(k)};
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      checkVal("sat_drop_count", drop_count, 16'hFFFF);
      checkVal("sat_overflow", overflow, 1);
      checkVal("sat_full", full, 1);
      checkVal("sat_level", level, 258);
      clear = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0; in_valid = 1'b0;
      checkVal("sat_clear_drop_count", drop_count, 0);
      checkVal("sat_clear_overflow", overflow, 0);
      checkVal("sat_clear_level", level, 0);
      checkVal("sat_clear_full", full, 0);
      checkVal("sat_clear_empty", empty, 1);

      checkVal("write_mask_all_ones", 64'(mask_err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
